// File: rtl/dart_throw_gen.sv
// dart_throw_gen: throw sequencer that drives a dart scorer for board-level demo and self-check.
//
// On start it issues pseudo-random throws as single-cycle dart_come_o strobes, one every GAP+1
// cycles. Coordinates come from a 16-bit Fibonacci LFSR that keeps running across games. It
// follows player-turn alternation from the scorer's done pulses and latches the winner and final
// points when game_set_i arrives. A game with no result after MAX_THROWS throws is aborted with
// err_o set.
//
// Ports
//   clk, reset                 rising-edge clock, asynchronous active-high reset
//   start_i                    level, begins a game when idle or finished
//   dart_come_o                one-cycle throw strobe to the scorer
//   dart_position_x_o/_y_o     throw coordinates, held between throws
//   game_set_i                 scorer reports game over
//   player_1/2_done_i          one-cycle end-of-turn pulses from the scorer
//   player_1/2_win_i           winner flags, valid while game_set_i is high
//   player_1/2_pt_i            remaining points from the scorer
//   busy_o, finished_o         game in progress / result latched
//   winner_o                   {p2_win, p1_win} captured at game end
//   p1_final_pt_o/p2_final_pt_o points captured at game end
//   throw_cnt_o, turn_cnt_o    throws issued / done pulses seen this game
//   err_o                      sticky protocol or consistency error for this game
module dart_throw_gen #(
  parameter int unsigned GAP        = 4,
  parameter int unsigned MAX_THROWS = 200,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  output logic       dart_come_o,
  output logic [7:0] dart_position_x_o,
  output logic [7:0] dart_position_y_o,
  input  logic       game_set_i,
  input  logic       player_1_done_i,
  input  logic       player_2_done_i,
  input  logic       player_1_win_i,
  input  logic       player_2_win_i,
  input  logic [8:0] player_1_pt_i,
  input  logic [8:0] player_2_pt_i,
  output logic       busy_o,
  output logic       finished_o,
  output logic [1:0] winner_o,
  output logic [8:0] p1_final_pt_o,
  output logic [8:0] p2_final_pt_o,
  output logic [7:0] throw_cnt_o,
  output logic [7:0] turn_cnt_o,
  output logic       err_o
);

  localparam logic [7:0] GapLoad   = 8'(GAP);
  localparam logic [7:0] MaxThrows = 8'(MAX_THROWS);

  typedef enum logic [1:0] {StIdle, StThrow, StGap, StDone} state_e;

  state_e      state_q, state_d;

  logic [15:0] lfsr_q, lfsr_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic [7:0]  throw_cnt_q, throw_cnt_d;
  logic [7:0]  turn_cnt_q, turn_cnt_d;
  logic        exp_p2_q, exp_p2_d;     // 0: player 1 owes the next done pulse
  logic        err_q, err_d;
  logic        dart_come_q, dart_come_d;
  logic        busy_q, busy_d;
  logic        finished_q, finished_d;
  logic [7:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic [1:0]  winner_q, winner_d;
  logic [8:0]  p1_pt_q, p1_pt_d;
  logic [8:0]  p2_pt_q, p2_pt_d;

  logic        in_play;
  logic        gap_expire;
  logic        throws_spent;
  logic        new_game;
  logic        enter_throw;
  logic        capture;
  logic        abort;
  logic        lfsr_fb;

  assign in_play      = (state_q == StThrow) || (state_q == StGap);
  // Counter is loaded with GAP and the last GAP cycle is the one holding 1, so exactly GAP
  // cycles are spent in StGap.
  assign gap_expire   = (state_q == StGap) && (gap_cnt_q == 8'd1);
  assign throws_spent = (throw_cnt_q == MaxThrows);
  assign lfsr_fb      = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  // ---------------------------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Next-state logic; game_set_i always wins over a pending throw
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start_i) state_d = StThrow;
      end
      StThrow: begin
        state_d = game_set_i ? StDone : StGap;
      end
      StGap: begin
        if (game_set_i) begin
          state_d = StDone;
        end else if (gap_expire) begin
          state_d = throws_spent ? StDone : StThrow;
        end
      end
      StDone: begin
        if (start_i) state_d = StThrow;
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // Output and datapath next-state logic
  // ---------------------------------------------------------------------------------------------
  assign new_game    = ((state_q == StIdle) || (state_q == StDone)) && start_i;
  assign enter_throw = (state_d == StThrow);
  assign capture     = in_play && game_set_i;
  assign abort       = (state_q == StGap) && !game_set_i && gap_expire && throws_spent;

  always_comb begin
    lfsr_d      = lfsr_q;
    gap_cnt_d   = gap_cnt_q;
    throw_cnt_d = throw_cnt_q;
    turn_cnt_d  = turn_cnt_q;
    exp_p2_d    = exp_p2_q;
    err_d       = err_q;
    x_d         = x_q;
    y_d         = y_q;
    winner_d    = winner_q;
    p1_pt_d     = p1_pt_q;
    p2_pt_d     = p2_pt_q;

    dart_come_d = enter_throw;
    busy_d      = (state_d == StThrow) || (state_d == StGap);
    finished_d  = (state_d == StDone);

    if (new_game) begin
      throw_cnt_d = 8'd0;
      turn_cnt_d  = 8'd0;
      exp_p2_d    = 1'b0;
      err_d       = 1'b0;
      winner_d    = 2'b00;
      p1_pt_d     = 9'd0;
      p2_pt_d     = 9'd0;
    end

    if (state_q == StThrow) begin
      gap_cnt_d = GapLoad;
    end else if (state_q == StGap) begin
      gap_cnt_d = gap_cnt_q - 8'd1;
    end

    // Coordinates are taken from the current LFSR value, which then steps on the same edge.
    if (enter_throw) begin
      x_d         = lfsr_q[7:0];
      y_d         = lfsr_q[15:8];
      lfsr_d      = {lfsr_q[14:0], lfsr_fb};
      throw_cnt_d = (new_game ? 8'd0 : throw_cnt_q) + 8'd1;
    end

    // Turn tracking; a double pulse counts as one turn and is always an error.
    if (in_play && (player_1_done_i || player_2_done_i)) begin
      turn_cnt_d = (turn_cnt_q == 8'hFF) ? turn_cnt_q : turn_cnt_q + 8'd1;
      exp_p2_d   = ~exp_p2_q;
      if (player_1_done_i && player_2_done_i) begin
        err_d = 1'b1;
      end else if (player_1_done_i && exp_p2_q) begin
        err_d = 1'b1;
      end else if (player_2_done_i && !exp_p2_q) begin
        err_d = 1'b1;
      end
    end

    if (capture) begin
      winner_d = {player_2_win_i, player_1_win_i};
      p1_pt_d  = player_1_pt_i;
      p2_pt_d  = player_2_pt_i;
      // Exactly one winner is the only consistent result.
      if (player_1_win_i == player_2_win_i) err_d = 1'b1;
    end

    if (abort) begin
      err_d    = 1'b1;
      winner_d = 2'b00;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q      <= LFSR_SEED;
      gap_cnt_q   <= 8'd0;
      throw_cnt_q <= 8'd0;
      turn_cnt_q  <= 8'd0;
      exp_p2_q    <= 1'b0;
      err_q       <= 1'b0;
      dart_come_q <= 1'b0;
      busy_q      <= 1'b0;
      finished_q  <= 1'b0;
      x_q         <= 8'h00;
      y_q         <= 8'h00;
      winner_q    <= 2'b00;
      p1_pt_q     <= 9'd0;
      p2_pt_q     <= 9'd0;
    end else begin
      lfsr_q      <= lfsr_d;
      gap_cnt_q   <= gap_cnt_d;
      throw_cnt_q <= throw_cnt_d;
      turn_cnt_q  <= turn_cnt_d;
      exp_p2_q    <= exp_p2_d;
      err_q       <= err_d;
      dart_come_q <= dart_come_d;
      busy_q      <= busy_d;
      finished_q  <= finished_d;
      x_q         <= x_d;
      y_q         <= y_d;
      winner_q    <= winner_d;
      p1_pt_q     <= p1_pt_d;
      p2_pt_q     <= p2_pt_d;
    end
  end

  assign dart_come_o       = dart_come_q;
  assign dart_position_x_o = x_q;
  assign dart_position_y_o = y_q;
  assign busy_o            = busy_q;
  assign finished_o        = finished_q;
  assign winner_o          = winner_q;
  assign p1_final_pt_o     = p1_pt_q;
  assign p2_final_pt_o     = p2_pt_q;
  assign throw_cnt_o       = throw_cnt_q;
  assign turn_cnt_o        = turn_cnt_q;
  assign err_o             = err_q;

endmodule

// File: tb/tb_dart_throw_gen.sv
// Self-checking bench for dart_throw_gen: a behavioural game model (phase counting, turn
// bookkeeping, LFSR sequence) is checked against the DUT on every falling edge, plus directed
// literal checks for the reset state, the first coordinates and the game-end scenarios.
module tb_dart_throw_gen;

  localparam int unsigned GAP        = 4;
  localparam int unsigned MAX_THROWS = 3;
  localparam logic [15:0] SEED       = 16'hACE1;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_i;
  logic       dart_come_o;
  logic [7:0] dart_position_x_o;
  logic [7:0] dart_position_y_o;
  logic       game_set_i;
  logic       player_1_done_i;
  logic       player_2_done_i;
  logic       player_1_win_i;
  logic       player_2_win_i;
  logic [8:0] player_1_pt_i;
  logic [8:0] player_2_pt_i;
  logic       busy_o;
  logic       finished_o;
  logic [1:0] winner_o;
  logic [8:0] p1_final_pt_o;
  logic [8:0] p2_final_pt_o;
  logic [7:0] throw_cnt_o;
  logic [7:0] turn_cnt_o;
  logic       err_o;

  dart_throw_gen #(
    .GAP       (GAP),
    .MAX_THROWS(MAX_THROWS),
    .LFSR_SEED (SEED)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start_i          (start_i),
    .dart_come_o      (dart_come_o),
    .dart_position_x_o(dart_position_x_o),
    .dart_position_y_o(dart_position_y_o),
    .game_set_i       (game_set_i),
    .player_1_done_i  (player_1_done_i),
    .player_2_done_i  (player_2_done_i),
    .player_1_win_i   (player_1_win_i),
    .player_2_win_i   (player_2_win_i),
    .player_1_pt_i    (player_1_pt_i),
    .player_2_pt_i    (player_2_pt_i),
    .busy_o           (busy_o),
    .finished_o       (finished_o),
    .winner_o         (winner_o),
    .p1_final_pt_o    (p1_final_pt_o),
    .p2_final_pt_o    (p2_final_pt_o),
    .throw_cnt_o      (throw_cnt_o),
    .turn_cnt_o       (turn_cnt_o),
    .err_o            (err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // Behavioural model of the game
  bit          m_active;
  bit          m_finished;
  int          m_phase;    // cycles since the last throw; 0 in the strobe cycle
  int          m_throws;
  int          m_turns;
  int          m_expect;   // player (1 or 2) owing the next done pulse
  bit          m_err;
  logic [1:0]  m_winner;
  logic [8:0]  m_p1;
  logic [8:0]  m_p2;
  logic [7:0]  m_x;
  logic [7:0]  m_y;
  logic [15:0] m_lfsr;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  task automatic model_reset();
    m_active   = 1'b0;
    m_finished = 1'b0;
    m_phase    = 0;
    m_throws   = 0;
    m_turns    = 0;
    m_expect   = 1;
    m_err      = 1'b0;
    m_winner   = 2'b00;
    m_p1       = 9'd0;
    m_p2       = 9'd0;
    m_x        = 8'h00;
    m_y        = 8'h00;
    m_lfsr     = SEED;
  endtask

  task automatic model_throw();
    m_phase  = 0;
    m_throws = m_throws + 1;
    m_x      = m_lfsr[7:0];
    m_y      = m_lfsr[15:8];
    m_lfsr   = lfsr_next(m_lfsr);
  endtask

  // One rising edge of the game, using the inputs present at that edge.
  task automatic model_step();
    if (reset) begin
      model_reset();
    end else if (!m_active) begin
      if (start_i) begin
        m_active   = 1'b1;
        m_finished = 1'b0;
        m_throws   = 0;
        m_turns    = 0;
        m_expect   = 1;
        m_err      = 1'b0;
        m_winner   = 2'b00;
        m_p1       = 9'd0;
        m_p2       = 9'd0;
        model_throw();
      end
    end else begin
      if (player_1_done_i || player_2_done_i) begin
        if (m_turns < 255) m_turns = m_turns + 1;
        if (player_1_done_i && player_2_done_i) m_err = 1'b1;
        else if (player_1_done_i && m_expect != 1) m_err = 1'b1;
        else if (player_2_done_i && m_expect != 2) m_err = 1'b1;
        m_expect = 3 - m_expect;
      end
      if (game_set_i) begin
        m_active   = 1'b0;
        m_finished = 1'b1;
        m_winner   = {player_2_win_i, player_1_win_i};
        m_p1       = player_1_pt_i;
        m_p2       = player_2_pt_i;
        if (player_1_win_i == player_2_win_i) m_err = 1'b1;
      end else if (m_phase == int'(GAP)) begin
        if (m_throws == int'(MAX_THROWS)) begin
          m_active   = 1'b0;
          m_finished = 1'b1;
          m_err      = 1'b1;
          m_winner   = 2'b00;
        end else begin
          model_throw();
        end
      end else begin
        m_phase = m_phase + 1;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_scorer();
    game_set_i      = 1'b0;
    player_1_done_i = 1'b0;
    player_2_done_i = 1'b0;
    player_1_win_i  = 1'b0;
    player_2_win_i  = 1'b0;
    player_1_pt_i   = 9'd0;
    player_2_pt_i   = 9'd0;
  endtask

  // Compare process: every falling edge, all outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("dart_come", 16'(dart_come_o), 16'(m_active && m_phase == 0));
      check("pos_x", 16'(dart_position_x_o), 16'(m_x));
      check("pos_y", 16'(dart_position_y_o), 16'(m_y));
      check("busy", 16'(busy_o), 16'(m_active));
      check("finished", 16'(finished_o), 16'(m_finished));
      check("winner", 16'(winner_o), 16'(m_winner));
      check("p1_final", 16'(p1_final_pt_o), 16'(m_p1));
      check("p2_final", 16'(p2_final_pt_o), 16'(m_p2));
      check("throw_cnt", 16'(throw_cnt_o), 16'(m_throws));
      check("turn_cnt", 16'(turn_cnt_o), 16'(m_turns));
      check("err", 16'(err_o), 16'(m_err));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int strobes;
    reset   = 1'b1;
    start_i = 1'b0;
    clear_scorer();
    model_reset();
    cycle();
    cycle();
    chk_en = 1'b1;

    // Reset state
    check("rst_dart_come", 16'(dart_come_o), 16'h0);
    check("rst_xy", {dart_position_y_o, dart_position_x_o}, 16'h0000);
    check("rst_status", 16'({busy_o, finished_o, err_o, winner_o}), 16'h0);
    check("rst_cnts", {throw_cnt_o, turn_cnt_o}, 16'h0000);

    // First throw from the seed
    reset   = 1'b0;
    start_i = 1'b1;
    cycle();
    start_i = 1'b0;
    check("t1_strobe", 16'(dart_come_o), 16'h1);
    check("t1_x", 16'(dart_position_x_o), 16'h00E1);
    check("t1_y", 16'(dart_position_y_o), 16'h00AC);
    check("t1_busy", 16'(busy_o), 16'h1);

    // Correct alternation: p1 then p2
    player_1_done_i = 1'b1;
    cycle();
    player_1_done_i = 1'b0;
    player_2_done_i = 1'b1;
    cycle();
    player_2_done_i = 1'b0;
    check("alt_turns", 16'(turn_cnt_o), 16'd2);
    check("alt_err", 16'(err_o), 16'h0);
    cycle();
    cycle();
    check("gap_no_strobe", 16'(dart_come_o), 16'h0);
    cycle();
    check("t2_strobe", 16'(dart_come_o), 16'h1);
    check("t2_x", 16'(dart_position_x_o), 16'h00C3);
    check("t2_y", 16'(dart_position_y_o), 16'h0059);
    check("t2_cnt", 16'(throw_cnt_o), 16'd2);

    // Second p2 pulse in a row
    player_2_done_i = 1'b1;
    cycle();
    player_2_done_i = 1'b0;
    check("dup_p2_err", 16'(err_o), 16'h1);

    // Game over at the edge that would issue throw 3
    cycle();
    cycle();
    cycle();
    game_set_i     = 1'b1;
    player_1_win_i = 1'b1;
    player_2_pt_i  = 9'd137;
    cycle();
    clear_scorer();
    check("gs_no_strobe", 16'(dart_come_o), 16'h0);
    check("gs_finished", 16'(finished_o), 16'h1);
    check("gs_winner", 16'(winner_o), 16'b01);
    check("gs_p1", 16'(p1_final_pt_o), 16'd0);
    check("gs_p2", 16'(p2_final_pt_o), 16'd137);
    check("gs_busy", 16'(busy_o), 16'h0);
    cycle();
    cycle();

    // Throw limit with no result
    start_i = 1'b1;
    cycle();
    start_i = 1'b0;
    strobes = int'(dart_come_o);
    for (int i = 0; i < 19; i++) begin
      cycle();
      strobes += int'(dart_come_o);
    end
    check("max_strobes", 16'(strobes), 16'd3);
    check("max_finished", 16'(finished_o), 16'h1);
    check("max_err", 16'(err_o), 16'h1);
    check("max_winner", 16'(winner_o), 16'b00);
    check("max_cnt", 16'(throw_cnt_o), 16'd3);

    // Both win flags
    start_i = 1'b1;
    cycle();
    start_i        = 1'b0;
    game_set_i     = 1'b1;
    player_1_win_i = 1'b1;
    player_2_win_i = 1'b1;
    cycle();
    clear_scorer();
    check("both_err", 16'(err_o), 16'h1);
    check("both_winner", 16'(winner_o), 16'b11);

    // Reset during GAP
    start_i = 1'b1;
    cycle();
    start_i = 1'b0;
    cycle();
    cycle();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("mid_rst_strobe", 16'(dart_come_o), 16'h0);
    check("mid_rst_xy", {dart_position_y_o, dart_position_x_o}, 16'h0000);
    check("mid_rst_status", 16'({busy_o, finished_o, err_o, winner_o}), 16'h0);
    check("mid_rst_cnts", {throw_cnt_o, turn_cnt_o}, 16'h0000);
    cycle();
    reset   = 1'b0;
    start_i = 1'b1;
    cycle();
    start_i = 1'b0;
    check("rst_t1_x", 16'(dart_position_x_o), 16'h00E1);
    check("rst_t1_y", 16'(dart_position_y_o), 16'h00AC);

    // Randomised play against the model
    for (int i = 0; i < 3000; i++) begin
      start_i         = ($urandom_range(0, 3) == 0);
      game_set_i      = ($urandom_range(0, 9) == 0);
      player_1_done_i = ($urandom_range(0, 3) == 0);
      player_2_done_i = ($urandom_range(0, 3) == 0);
      player_1_win_i  = 1'($urandom_range(0, 1));
      player_2_win_i  = 1'($urandom_range(0, 1));
      player_1_pt_i   = 9'($urandom_range(0, 511));
      player_2_pt_i   = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1;
        model_reset();
      end else begin
        reset = 1'b0;
      end
      cycle();
    end

    reset   = 1'b0;
    start_i = 1'b0;
    clear_scorer();
    cycle();
    cycle();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dart_throw_gen.md
# dart_throw_gen

Synthesizable throw sequencer that drives the dart scoring block's input side and consumes its result side, for board-level demo and self-check without a simulation pattern. On start it issues pseudo-random throws (16-bit LFSR coordinates) as single-cycle `dart_come` pulses. It tracks player-turn alternation from the scorer's done pulses, and latches winner and final points when `game_set` rises. It sits opposite the `dart` scorer, port-for-port mirrored, with a small status bus toward the board controller.

## Interface
- `GAP`, default 4: idle cycles between consecutive throws (1..255).
- `MAX_THROWS`, default 200: throw limit before the game is aborted (1..255).
- `LFSR_SEED`, default 16'hACE1: LFSR reset value; must be nonzero.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start_i`  in  1  level; sampled in IDLE or DONE to begin a game.
- `dart_come_o`  out  1  one-cycle throw strobe to scorer.
- `dart_position_x_o`  out  8  throw x coordinate.
- `dart_position_y_o`  out  8  throw y coordinate.
- `game_set_i`  in  1  scorer reports game over.
- `player_1_done_i`, `player_2_done_i`  in  1 each  one-cycle end-of-turn pulses from scorer.
- `player_1_win_i`, `player_2_win_i`  in  1 each  winner flags, valid while `game_set_i`=1.
- `player_1_pt_i`, `player_2_pt_i`  in  9 each  remaining points from scorer.
- `busy_o`  out  1  game in progress.
- `finished_o`  out  1  result latched.
- `winner_o`  out  2  {p2_win, p1_win} captured at game end.
- `p1_final_pt_o`, `p2_final_pt_o`  out  9 each  points captured at game end.
- `throw_cnt_o`  out  8  throws issued this game.
- `turn_cnt_o`  out  8  done pulses seen this game.
- `err_o`  out  1  sticky protocol/consistency error for this game.

## Operation
- FSM states: IDLE, THROW, GAP, DONE. All outputs are registered.
- IDLE: `busy_o`=0. `start_i`=1 → THROW. Entering THROW from IDLE or DONE clears the throw/turn counters, `err_o`, `finished_o`, `winner_o` and the point captures.
- THROW: lasts exactly one cycle with `dart_come_o`=1.
  - x/y are loaded on the edge entering THROW: x = lfsr[7:0], y = lfsr[15:8].
  - The LFSR advances on that same edge.
  - x/y then hold until the next THROW.
  - `throw_cnt_o` increments on the same edge.
  - Next state is GAP, with the gap counter loaded to GAP.
- GAP: counter decrements each cycle. At 0:
  - if `throw_cnt_o` = MAX_THROWS → DONE with `err_o`=1 and `winner_o`=0.
  - else → THROW.
- LFSR: Fibonacci, taps 16,14,13,11; new bit = l[15]^l[13]^l[12]^l[10], shifted into bit 0. It is reset only by `reset` and continues across games.
- `game_set_i`=1 in THROW or GAP → DONE on the next edge. It has priority over issuing a throw. On that edge, capture `winner_o`, `p1_final_pt_o` and `p2_final_pt_o` from the inputs.
- Error conditions at capture (each sets `err_o`):
  - both win flags high;
  - neither win flag high.
- DONE: `finished_o`=1, `busy_o`=0, results held. `start_i`=1 → new game (THROW).
- Turn tracking in THROW and GAP:
  - the expected player starts as 1 each game and toggles on each done pulse;
  - each pulse increments `turn_cnt_o`, saturating at 255;
  - a pulse from the unexpected player sets `err_o`;
  - both done pulses in the same cycle set `err_o` and increment once.
- Done or win inputs outside THROW/GAP are ignored.

## Timing
- Reset values:
  - state IDLE; LFSR = LFSR_SEED;
  - all outputs 0, including x/y = 8'h00.
- Latency: `start_i` sampled high at edge N → `dart_come_o` high in cycle N+1.
- Throw period: GAP+1 cycles (THROW cycle plus GAP cycles).
- `game_set_i` sampled at edge M → `finished_o`=1 and captures valid from cycle M+1. No `dart_come_o` is issued in cycle M+1 or after.
- Reset mid-game: everything returns to reset values immediately, with no further strobe.

## Test plan
- Reset, GAP=4, `start_i` pulsed at edge 1:
  - `dart_come_o` high in cycle 2 only, with x=8'hE1, y=8'hAC;
  - next strobe in cycle 7 with x/y from the advanced LFSR;
  - `throw_cnt_o`=2.
- Scorer model asserts `player_1_done_i` then `player_2_done_i` on alternate turns → `turn_cnt_o`=2, `err_o`=0. A second `player_2_done_i` in a row → `err_o`=1.
- `game_set_i`=1 with `player_1_win_i`=1, p1_pt=0, p2_pt=9'd137 in the same cycle as a pending throw:
  - no strobe;
  - `finished_o`=1 next cycle, `winner_o`=2'b01, `p1_final_pt_o`=0, `p2_final_pt_o`=137.
- MAX_THROWS=3, scorer never sets game:
  - exactly 3 strobes;
  - then DONE with `err_o`=1, `winner_o`=0, `throw_cnt_o`=3.
- `game_set_i` with both win flags high → `err_o`=1, `winner_o`=2'b11.
- Assert `reset` during GAP → `dart_come_o`, x/y and all status return to 0 immediately. After release and start, the first throw again yields x=8'hE1, y=8'hAC.
